load_exec_unit: RTL and testbench
=================================

# load_exec_unit

Executes decoded load instructions. Consumes a `tOpLoad` descriptor from the decode stage together with the base register value. Computes the effective address, checks alignment and size, and runs a request/grant/response handshake with the data memory port. Returns the aligned, sign- or zero-extended result to the register file through a `tRegControl` write port. Sits between the decoder and the data-memory interface, as the consuming end of the `tOpLoad` path.

## Interface
- `cDataWidth`, 32, data and address width; only 32 supported
- `cRegSelBitW`, 5, register select width
- `clk`  in  1  clock, rising edge
- `rstn`  in  1  asynchronous, active-low reset
- `iLoad`  in  `tOpLoad`  decoded load; `dv` = valid, `size` = funct3, `imm` = 12-bit signed offset
- `iRs1Data`  in  32  value of register `iLoad.srcAddr`; valid in the same cycle as `iLoad.dv`
- `oReady`  out  1  high only in IDLE; a load is accepted on `iLoad.dv & oReady`
- `oMemReq`  out  1  memory read request; held until granted
- `oMemAddr`  out  32  word-aligned address (`addr[1:0]=0`)
- `iMemGnt`  in  1  request accepted
- `iMemRdv`  in  1  read data valid; arrives no earlier than the cycle after grant
- `iMemRdata`  in  32  read word
- `oWb`  out  `tRegControl`  writeback enable and destination address
- `oWbData`  out  32  writeback value
- `oExc`  out  1  one-cycle pulse on a misaligned or illegal-size load
- `oExcAddr`  out  32  effective address of the faulting load

## Operation
- Effective address: `ea = iRs1Data + sext(imm)`, computed modulo 2^32 so wrap-around is silent. `ea` is registered at accept together with `size` and `destAddr`.
- Legal `size` encodings:
  - 000 LB
  - 001 LH
  - 010 LW
  - 100 LBU
  - 101 LHU
- Illegal size: any other encoding. `oExc` pulses and no memory access is made.
- Misaligned: LH/LHU with `ea[0]=1`, or LW with `ea[1:0]≠0`. `oExc` pulses, `oExcAddr=ea`, and no memory access is made.
- States:
  - IDLE → REQ on accept of a legal, aligned load.
  - IDLE → EXC on accept of an illegal or misaligned load.
  - EXC → IDLE unconditionally.
  - REQ → WAIT when `iMemGnt`.
  - WAIT → WB when `iMemRdv`.
  - WB → IDLE unconditionally.
- In REQ: `oMemReq=1`, `oMemAddr={ea[31:2],2'b00}`, both stable until granted.
- Extraction in WAIT on `iMemRdv`:
  - byte = `rdata[8*ea[1:0] +: 8]`
  - half = `rdata[16*ea[1] +: 16]`
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
  - The result is registered into `oWbData`.
- In WB: `oWb.en=1` for one cycle and `oWb.addr=destAddr`. If `destAddr=0`, `oWb.en` stays 0, but the memory access is still performed.
- `iLoad.dv` while not in IDLE is ignored. Upstream holds `dv` until it is accepted.
- `iMemGnt` outside REQ and `iMemRdv` outside WAIT are ignored.
- Reset, including mid-transaction:
  - The FSM returns to IDLE asynchronously.
  - All outputs go to 0 except `oReady=1`.
  - A response still in flight from before reset arrives in IDLE and is discarded.

## Timing
- Zero-wait memory (grant in the first REQ cycle, `rdv` one cycle later):
  - T: accept
  - T+1: `oMemReq=1` (REQ)
  - T+2: WAIT, `rdv` arrives
  - T+3: `oWb.en=1` (WB)
  - T+4: `oReady=1`
- Minimum accept-to-writeback latency is 3 cycles. Each wait cycle on `gnt` or `rdv` adds exactly one cycle.
- Exception path: accept at T, `oExc` pulses at T+1 (EXC), `oReady=1` at T+2.
- Throughput: one load per 4 cycles minimum. No pipelining.
- All outputs are registered.

## Structure
- Add to `corePckg`:
  - `tLoadSize` enum: LB, LH, LW, LBU, LHU with the encodings above.
  - `tLoadState` enum: IDLE, REQ, WAIT, WB, EXC.
  - `cAddrWidth = 32`.
- Sub-module `load_data_align`: purely combinational. Inputs are the word, `ea[1:0]` and `size`; output is the extended 32-bit value. It is also reusable by a future store unit's inverse path.

## Test plan
- LW, `rs1=0x1000`, `imm=4`, rdata `0xDEADBEEF`, zero-wait memory:
  - `oMemAddr=0x1004` at T+1.
  - `oWb.en=1`, `oWbData=0xDEADBEEF` at T+3.
- LB/LBU, `ea=0x2003`, rdata `0x80FF7F01`:
  - LB gives `0xFFFFFF80`; LBU gives `0x00000080`.
  - LH at `ea=0x2002` gives `0xFFFF80FF`.
- LH with `ea=0x3001`:
  - `oExc` pulses at T+1 with `oExcAddr=0x3001`.
  - `oMemReq` never asserts.
  - Size 011 likewise raises `oExc`.
- Back-pressure: `gnt` held low 3 cycles and `rdv` 2 cycles after grant.
  - `oMemReq`/`oMemAddr` stay stable throughout.
  - Writeback lands at T+8.
  - A second `dv` during the load is not accepted until `oReady`.
- `destAddr=0`: the memory access occurs and `oWb.en` stays 0. Separately, `rs1=0xFFFFFFFC`, `imm=8` wraps to `oMemAddr=0x4`.
- Reset asserted in WAIT:
  - Outputs clear immediately.
  - A subsequent `rdv` produces no writeback.
  - The next load after reset completes normally.

Source files
------------

// File: rtl/load_exec_unit_pkg.sv
// Shared types for the load execution path: decoded load descriptor,
// register-file write control, load size encodings and unit FSM states.
package load_exec_unit_pkg;

  localparam int unsigned cAddrWidth = 32;
  localparam int unsigned cRegSelW   = 5;

  // Values are the funct3 encodings of the load instructions
  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } tLoadSize;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    WB,
    EXC
  } tLoadState;

  typedef struct packed {
    logic                dv;
    logic [cRegSelW-1:0] srcAddr;
    logic [cRegSelW-1:0] destAddr;
    logic [2:0]          size;
    logic [11:0]         imm;
  } tOpLoad;

  typedef struct packed {
    logic                en;
    logic [cRegSelW-1:0] addr;
  } tRegControl;

  // High when the size encoding is illegal or the byte offset breaks natural alignment
  function automatic logic load_fault(input logic [2:0] size, input logic [1:0] off);
    case (size)
      LB, LBU: load_fault = 1'b0;
      LH, LHU: load_fault = off[0];
      LW:      load_fault = |off;
      default: load_fault = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_exec_unit_if.sv
// Data-memory read port: request/grant handshake followed by a read-valid response.
interface load_exec_unit_if;
  import load_exec_unit_pkg::*;

  logic                  oMemReq;
  logic [cAddrWidth-1:0] oMemAddr;
  logic                  iMemGnt;
  logic                  iMemRdv;
  logic [cAddrWidth-1:0] iMemRdata;

  modport master (
    output oMemReq,
    output oMemAddr,
    input  iMemGnt,
    input  iMemRdv,
    input  iMemRdata
  );

  modport slave (
    input  oMemReq,
    input  oMemAddr,
    output iMemGnt,
    output iMemRdv,
    output iMemRdata
  );

endinterface

// File: rtl/load_exec_unit_align.sv
// Combinational lane select and sign/zero extension of a loaded word.
// Kept standalone so a store unit can reuse the lane mapping.
module load_data_align
  import load_exec_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  tLoadSize    size,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];

    case (size)
      LB:      data = {{24{b[7]}}, b};
      LBU:     data = {24'b0, b};
      LH:      data = {{16{h[15]}}, h};
      LHU:     data = {16'b0, h};
      LW:      data = word;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/load_exec_unit.sv
// Load execution unit: effective address, alignment/size check, memory
// request/grant/response handshake and extended writeback. One load at a time.
module load_exec_unit
  import load_exec_unit_pkg::*;
#(
  parameter int unsigned cDataWidth  = 32,
  parameter int unsigned cRegSelBitW = 5
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  tOpLoad                  iLoad,
  input  logic [cDataWidth-1:0]   iRs1Data,
  output logic                    oReady,
  load_exec_unit_if.master        mem,
  output tRegControl              oWb,
  output logic [cDataWidth-1:0]   oWbData,
  output logic                    oExc,
  output logic [cDataWidth-1:0]   oExcAddr
);

  tLoadState              state;
  logic [1:0]             off_q;
  tLoadSize               size_q;
  logic [cRegSelBitW-1:0] dest_q;
  logic [cDataWidth-1:0]  ea;
  logic [cDataWidth-1:0]  aligned;
  logic                   fault;
  logic                   unused_src;

  // Wraps modulo 2^32 by construction
  assign ea         = iRs1Data + {{(cDataWidth-12){iLoad.imm[11]}}, iLoad.imm};
  assign fault      = load_fault(iLoad.size, ea[1:0]);
  assign unused_src = ^iLoad.srcAddr;

  load_data_align u_align (
    .word (mem.iMemRdata),
    .off  (off_q),
    .size (size_q),
    .data (aligned)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      oReady       <= 1'b1;
      mem.oMemReq  <= 1'b0;
      mem.oMemAddr <= '0;
      oWb          <= '0;
      oWbData      <= '0;
      oExc         <= 1'b0;
      oExcAddr     <= '0;
      off_q        <= '0;
      size_q       <= LB;
      dest_q       <= '0;
    end else begin
      oExc   <= 1'b0;
      oWb.en <= 1'b0;
      case (state)
        IDLE: begin
          if (iLoad.dv) begin
            oReady <= 1'b0;
            off_q  <= ea[1:0];
            size_q <= tLoadSize'(iLoad.size);
            dest_q <= iLoad.destAddr;
            if (fault) begin
              state    <= EXC;
              oExc     <= 1'b1;
              oExcAddr <= ea;
            end else begin
              state        <= REQ;
              mem.oMemReq  <= 1'b1;
              mem.oMemAddr <= {ea[cDataWidth-1:2], 2'b00};
            end
          end
        end
        EXC: begin
          state  <= IDLE;
          oReady <= 1'b1;
        end
        REQ: begin
          if (mem.iMemGnt) begin
            state       <= WAIT;
            mem.oMemReq <= 1'b0;
          end
        end
        WAIT: begin
          if (mem.iMemRdv) begin
            state    <= WB;
            oWbData  <= aligned;
            oWb.addr <= dest_q;
            // x0 is never written, though the read itself still happened
            oWb.en   <= |dest_q;
          end
        end
        WB: begin
          state  <= IDLE;
          oReady <= 1'b1;
        end
        default: begin
          state  <= IDLE;
          oReady <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_exec_unit.sv
// Randomized and directed bench for load_exec_unit against a behavioural load model.
module tb_load_exec_unit;
  import load_exec_unit_pkg::*;

  logic        clk;
  logic        rstn;
  tOpLoad      load;
  logic [31:0] rs1_data;
  logic        oReady;
  tRegControl  oWb;
  logic [31:0] oWbData;
  logic        oExc;
  logic [31:0] oExcAddr;

  load_exec_unit_if mem ();

  load_exec_unit #(
    .cDataWidth  (32),
    .cRegSelBitW (5)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .iLoad    (load),
    .iRs1Data (rs1_data),
    .oReady   (oReady),
    .mem      (mem),
    .oWb      (oWb),
    .oWbData  (oWbData),
    .oExc     (oExc),
    .oExcAddr (oExcAddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit noise    = 1'b0;

  // Observations of one load, cycle numbers relative to the accept cycle (0)
  int          obs_req_cyc, obs_req_cycles, obs_exc_cyc, obs_exc_cnt;
  int          obs_wb_cyc, obs_wb_cnt, obs_ready_cyc;
  bit          obs_req_seen, obs_req_stable;
  logic [31:0] obs_req_addr, obs_exc_addr, obs_wb_data;
  logic [4:0]  obs_wb_addr;

  tOpLoad      next_load;
  logic [31:0] next_rs1;

  function automatic bit ref_fault(input logic [2:0] size, input logic [31:0] ea);
    case (size)
      3'd0, 3'd4: return 1'b0;
      3'd1, 3'd5: return (ea % 2) != 0;
      3'd2:       return (ea % 4) != 0;
      default:    return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] ref_value(input logic [2:0] size, input logic [31:0] ea,
                                            input logic [31:0] w);
    logic [31:0] v;
    case (size)
      3'd0, 3'd4: begin
        v = (w >> (8 * (ea % 4))) & 32'hFF;
        if (size == 3'd0 && v >= 32'd128) v = v - 32'd256;
      end
      3'd1, 3'd5: begin
        v = (w >> (16 * ((ea / 2) % 2))) & 32'hFFFF;
        if (size == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] sext12(input logic [11:0] imm);
    return {{20{imm[11]}}, imm};
  endfunction

  // Drives one load and plays the memory side with the requested wait counts
  task automatic run_load(input logic [2:0] size, input logic [31:0] rs1, input logic [11:0] imm,
                          input logic [4:0] dest, input logic [31:0] rdata,
                          input int gwait, input int rwait, input bit keep_dv);
    int cyc, gcnt, gcyc, rcyc, n;
    bit done;
    logic [31:0] rnd;
    obs_req_seen = 0; obs_req_cyc = -1; obs_req_addr = '0; obs_req_stable = 1; obs_req_cycles = 0;
    obs_exc_cyc = -1; obs_exc_cnt = 0; obs_exc_addr = '0;
    obs_wb_cyc = -1; obs_wb_cnt = 0; obs_wb_addr = '0; obs_wb_data = '0; obs_ready_cyc = -1;
    n = 0;
    while (!oReady && n < 50) begin @(negedge clk); n++; end
    rnd = $urandom;
    load.dv = 1'b1; load.size = size; load.imm = imm; load.destAddr = dest; load.srcAddr = rnd[4:0];
    rs1_data = rs1;
    @(negedge clk);
    if (keep_dv) begin
      load = next_load; rs1_data = next_rs1;
    end else begin
      load.dv = 1'b0; rs1_data = $urandom;
    end
    cyc = 1; gcnt = 0; gcyc = -1; rcyc = -1; done = 0;
    while (!done && cyc < 60) begin
      rnd = $urandom;
      mem.iMemGnt = 1'b0; mem.iMemRdv = 1'b0; mem.iMemRdata = $urandom;
      if (oExc) begin
        obs_exc_cnt++;
        if (obs_exc_cyc < 0) begin obs_exc_cyc = cyc; obs_exc_addr = oExcAddr; end
      end
      if (oWb.en) begin
        obs_wb_cnt++; obs_wb_cyc = cyc; obs_wb_addr = oWb.addr; obs_wb_data = oWbData;
      end
      if (mem.oMemReq) begin
        obs_req_cycles++;
        if (!obs_req_seen) begin
          obs_req_seen = 1; obs_req_cyc = cyc; obs_req_addr = mem.oMemAddr;
        end else if (mem.oMemAddr !== obs_req_addr) obs_req_stable = 0;
        if (gcyc < 0) begin
          if (gcnt == gwait) begin mem.iMemGnt = 1'b1; gcyc = cyc; rcyc = cyc + 1 + rwait; end
          gcnt++;
        end
      end else if (noise) mem.iMemGnt = rnd[1];
      if (cyc == rcyc) begin
        mem.iMemRdv = 1'b1; mem.iMemRdata = rdata;
      end else if (noise && !(gcyc >= 0 && cyc > gcyc && cyc < rcyc)) mem.iMemRdv = rnd[2];
      if (oReady) begin
        done = 1; obs_ready_cyc = cyc; mem.iMemGnt = 1'b0; mem.iMemRdv = 1'b0;
      end else begin
        @(negedge clk); cyc++;
      end
    end
  endtask

  task automatic test_reset();
    load = '0; rs1_data = '0;
    mem.iMemGnt = 1'b0; mem.iMemRdv = 1'b0; mem.iMemRdata = '0;
    rstn = 1'b1;
    #1 rstn = 1'b0;
    #1;
    n_checks++;
    if ({oReady, mem.oMemReq, oWb.en, oExc} !== 4'b1000 || mem.oMemAddr !== 32'h0 ||
        oWbData !== 32'h0 || oExcAddr !== 32'h0 || oWb.addr !== 5'h0) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b req=%b wb=%b exc=%b addr=%h wbd=%h exca=%h, want rdy=1 rest 0",
               oReady, mem.oMemReq, oWb.en, oExc, mem.oMemAddr, oWbData, oExcAddr);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    n_checks++;
    if (oReady !== 1'b1 || mem.oMemReq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got rdy=%b req=%b, want rdy=1 req=0", oReady, mem.oMemReq);
    end
  endtask

  task automatic test_lw_basic();
    run_load(3'b010, 32'h1000, 12'd4, 5'd5, 32'hDEADBEEF, 0, 0, 0);
    n_checks++;
    if (obs_req_cyc !== 1 || obs_req_addr !== 32'h1004) begin
      n_fail++; $display("FAIL lw_req: got cyc %0d addr %h, want cyc 1 addr 00001004", obs_req_cyc, obs_req_addr);
    end
    n_checks++;
    if (obs_wb_cnt !== 1 || obs_wb_cyc !== 3 || obs_wb_addr !== 5'd5) begin
      n_fail++; $display("FAIL lw_wb_timing: got cnt %0d cyc %0d rd %0d, want 1 3 5", obs_wb_cnt, obs_wb_cyc, obs_wb_addr);
    end
    n_checks++;
    if (obs_wb_data !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL lw_data: got %h want deadbeef", obs_wb_data);
    end
    n_checks++;
    if (obs_ready_cyc !== 4) begin
      n_fail++; $display("FAIL lw_ready: got cyc %0d want 4", obs_ready_cyc);
    end
  endtask

  task automatic test_byte_half();
    run_load(3'b000, 32'h2000, 12'd3, 5'd1, 32'h80FF7F01, 0, 0, 0);
    n_checks++;
    if (obs_wb_data !== 32'hFFFFFF80 || obs_req_addr !== 32'h2000) begin
      n_fail++; $display("FAIL lb: got %h addr %h, want ffffff80 addr 00002000", obs_wb_data, obs_req_addr);
    end
    run_load(3'b100, 32'h2000, 12'd3, 5'd2, 32'h80FF7F01, 0, 0, 0);
    n_checks++;
    if (obs_wb_data !== 32'h00000080) begin
      n_fail++; $display("FAIL lbu: got %h want 00000080", obs_wb_data);
    end
    run_load(3'b001, 32'h2000, 12'd2, 5'd3, 32'h80FF7F01, 0, 0, 0);
    n_checks++;
    if (obs_wb_data !== 32'hFFFF80FF) begin
      n_fail++; $display("FAIL lh: got %h want ffff80ff", obs_wb_data);
    end
  endtask

  task automatic test_exceptions();
    run_load(3'b001, 32'h3000, 12'd1, 5'd4, 32'h12345678, 0, 0, 0);
    n_checks++;
    if (obs_exc_cnt !== 1 || obs_exc_cyc !== 1 || obs_exc_addr !== 32'h3001) begin
      n_fail++; $display("FAIL lh_misaligned_exc: got cnt %0d cyc %0d addr %h, want 1 1 00003001",
                         obs_exc_cnt, obs_exc_cyc, obs_exc_addr);
    end
    n_checks++;
    if (obs_req_seen !== 1'b0 || obs_wb_cnt !== 0 || obs_ready_cyc !== 2) begin
      n_fail++; $display("FAIL lh_misaligned_side: got req %0d wb %0d ready %0d, want 0 0 2",
                         obs_req_seen, obs_wb_cnt, obs_ready_cyc);
    end
    run_load(3'b011, 32'h3000, 12'hFF8, 5'd4, 32'h12345678, 0, 0, 0);
    n_checks++;
    if (obs_exc_cnt !== 1 || obs_exc_addr !== 32'h2FF8 || obs_req_seen !== 1'b0) begin
      n_fail++; $display("FAIL illegal_size: got cnt %0d addr %h req %0d, want 1 00002ff8 0",
                         obs_exc_cnt, obs_exc_addr, obs_req_seen);
    end
  endtask

  task automatic test_back_to_back();
    next_load.dv = 1'b1; next_load.size = 3'b100; next_load.imm = 12'd1;
    next_load.destAddr = 5'd9; next_load.srcAddr = 5'd2;
    next_rs1 = 32'h7000;
    run_load(3'b010, 32'h6000, 12'h010, 5'd8, 32'hA5C3_0F1E, 3, 2, 1);
    n_checks++;
    if (obs_wb_cyc !== 8 || obs_wb_data !== 32'hA5C30F1E || obs_ready_cyc !== 9) begin
      n_fail++; $display("FAIL backpressure_wb: got cyc %0d data %h ready %0d, want 8 a5c30f1e 9",
                         obs_wb_cyc, obs_wb_data, obs_ready_cyc);
    end
    n_checks++;
    if (obs_req_cycles !== 4 || !obs_req_stable || obs_req_addr !== 32'h6010) begin
      n_fail++; $display("FAIL backpressure_req: got cycles %0d stable %0d addr %h, want 4 1 00006010",
                         obs_req_cycles, obs_req_stable, obs_req_addr);
    end
    run_load(3'b100, 32'h7000, 12'd1, 5'd9, 32'h0000AB00, 0, 0, 0);
    n_checks++;
    if (obs_wb_data !== 32'h000000AB || obs_wb_cyc !== 3 || obs_wb_addr !== 5'd9 || obs_req_addr !== 32'h7000) begin
      n_fail++; $display("FAIL second_load: got data %h cyc %0d rd %0d addr %h, want 000000ab 3 9 00007000",
                         obs_wb_data, obs_wb_cyc, obs_wb_addr, obs_req_addr);
    end
  endtask

  task automatic test_dest_zero_wrap();
    run_load(3'b010, 32'h0000_8000, 12'd0, 5'd0, 32'h11223344, 1, 0, 0);
    n_checks++;
    if (obs_req_seen !== 1'b1 || obs_wb_cnt !== 0 || obs_ready_cyc !== 5) begin
      n_fail++; $display("FAIL dest_zero: got req %0d wb %0d ready %0d, want 1 0 5",
                         obs_req_seen, obs_wb_cnt, obs_ready_cyc);
    end
    run_load(3'b010, 32'hFFFFFFFC, 12'd8, 5'd6, 32'h55AA55AA, 0, 0, 0);
    n_checks++;
    if (obs_req_addr !== 32'h4 || obs_wb_data !== 32'h55AA55AA) begin
      n_fail++; $display("FAIL addr_wrap: got addr %h data %h, want 00000004 55aa55aa", obs_req_addr, obs_wb_data);
    end
  endtask

  task automatic test_reset_mid();
    bit bad;
    load.dv = 1'b1; load.size = 3'b010; load.imm = 12'd0; load.destAddr = 5'd7; load.srcAddr = 5'd1;
    rs1_data = 32'h5000;
    @(negedge clk);
    load.dv = 1'b0;
    n_checks++;
    if (mem.oMemReq !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_req: got %b want 1", mem.oMemReq);
    end
    mem.iMemGnt = 1'b1;
    @(negedge clk);
    mem.iMemGnt = 1'b0;
    #2 rstn = 1'b0;
    #1;
    n_checks++;
    if ({oReady, mem.oMemReq, oWb.en, oExc} !== 4'b1000 || mem.oMemAddr !== 32'h0 ||
        oWbData !== 32'h0 || oExcAddr !== 32'h0 || oWb.addr !== 5'h0) begin
      n_fail++;
      $display("FAIL reset_mid_clear: got rdy=%b req=%b wb=%b exc=%b addr=%h wbd=%h exca=%h, want rdy=1 rest 0",
               oReady, mem.oMemReq, oWb.en, oExc, mem.oMemAddr, oWbData, oExcAddr);
    end
    @(negedge clk);
    rstn = 1'b1;
    mem.iMemRdv = 1'b1; mem.iMemRdata = 32'h12345678;
    @(negedge clk);
    mem.iMemRdv = 1'b0;
    bad = 0;
    repeat (3) begin
      if (oWb.en !== 1'b0 || oReady !== 1'b1 || mem.oMemReq !== 1'b0) bad = 1;
      @(negedge clk);
    end
    n_checks++;
    if (bad) begin
      n_fail++; $display("FAIL stale_rdv: got a writeback or busy state after reset, want none");
    end
    run_load(3'b101, 32'h5000, 12'd2, 5'd7, 32'hC001_0000, 0, 1, 0);
    n_checks++;
    if (obs_wb_data !== 32'h0000C001 || obs_wb_cyc !== 4 || obs_wb_addr !== 5'd7) begin
      n_fail++; $display("FAIL post_reset_load: got %h cyc %0d rd %0d, want 0000c001 4 7",
                         obs_wb_data, obs_wb_cyc, obs_wb_addr);
    end
  endtask

  task automatic test_random();
    logic [2:0]  size;
    logic [31:0] rs1, rdata, ea, rnd, expv;
    logic [11:0] imm;
    logic [4:0]  dest;
    int gw, rw;
    noise = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rnd = $urandom; size = rnd[2:0]; imm = rnd[14:3]; dest = rnd[19:15];
      rs1 = $urandom; rdata = $urandom;
      gw = $urandom_range(0, 3); rw = $urandom_range(0, 3);
      if (rnd[20]) rs1 = rs1 - ((rs1 + sext12(imm)) % 4);
      ea = rs1 + sext12(imm);
      run_load(size, rs1, imm, dest, rdata, gw, rw, 0);
      if (ref_fault(size, ea)) begin
        n_checks++;
        if (obs_exc_cnt !== 1 || obs_exc_cyc !== 1 || obs_exc_addr !== ea) begin
          n_fail++; $display("FAIL rand[%0d] exc: got cnt %0d cyc %0d addr %h, want 1 1 %h",
                             i, obs_exc_cnt, obs_exc_cyc, obs_exc_addr, ea);
        end
        n_checks++;
        if (obs_req_seen !== 1'b0 || obs_wb_cnt !== 0 || obs_ready_cyc !== 2) begin
          n_fail++; $display("FAIL rand[%0d] exc_side: got req %0d wb %0d ready %0d, want 0 0 2",
                             i, obs_req_seen, obs_wb_cnt, obs_ready_cyc);
        end
      end else begin
        expv = ref_value(size, ea, rdata);
        n_checks++;
        if (obs_exc_cnt !== 0 || obs_req_cyc !== 1 || obs_req_addr !== (ea & 32'hFFFFFFFC) ||
            !obs_req_stable || obs_req_cycles !== gw + 1) begin
          n_fail++; $display("FAIL rand[%0d] req: got exc %0d cyc %0d addr %h stable %0d cycles %0d, want 0 1 %h 1 %0d",
                             i, obs_exc_cnt, obs_req_cyc, obs_req_addr, obs_req_stable, obs_req_cycles,
                             ea & 32'hFFFFFFFC, gw + 1);
        end
        n_checks++;
        if (obs_ready_cyc !== 4 + gw + rw) begin
          n_fail++; $display("FAIL rand[%0d] ready: got cyc %0d want %0d", i, obs_ready_cyc, 4 + gw + rw);
        end
        if (dest != 5'd0) begin
          n_checks++;
          if (obs_wb_cnt !== 1 || obs_wb_cyc !== 3 + gw + rw || obs_wb_addr !== dest || obs_wb_data !== expv) begin
            n_fail++; $display("FAIL rand[%0d] wb: got cnt %0d cyc %0d rd %0d data %h, want 1 %0d %0d %h",
                               i, obs_wb_cnt, obs_wb_cyc, obs_wb_addr, obs_wb_data, 3 + gw + rw, dest, expv);
          end
        end else begin
          n_checks++;
          if (obs_wb_cnt !== 0) begin
            n_fail++; $display("FAIL rand[%0d] wb_x0: got %0d writebacks want 0", i, obs_wb_cnt);
          end
        end
      end
    end
    noise = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lw_basic();
    test_byte_half();
    test_exceptions();
    test_back_to_back();
    test_dest_zero_wrap();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before the end of test");
    $fatal(1);
  end

endmodule
